int_wb_arbiter: RTL

- Write-side master for the integer register file's single write port (waddr/wdata/wen).
- Merges two result sources into one registered write per cycle:
  - single-cycle ALU results, which take priority;
  - long-latency LSU results, buffered in a small FIFO.
- Keeps a per-register busy scoreboard for in-flight long-latency destinations, used by issue logic for RAW stalls.

---
 rtl/int_wb_arbiter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/int_wb_arbiter.sv
// -----------------------------------------------------------------------------
// int_wb_arbiter
//
// Write-side master for the integer register file's single write port.
// Each cycle one registered write is produced from one of two sources:
//   - single-cycle ALU results, which have priority and no backpressure;
//   - long-latency LSU results, queued in a DEPTH-entry FIFO and drained
//     in order whenever the ALU is idle.
// A 32-bit busy scoreboard tracks registers with an LSU write still
// outstanding; issue logic uses it for RAW stalls.
// Writes to x0 are consumed (the FIFO still pops) but never enabled.
//
// Optional feature macro: WB_STARVE_GUARD_EN
//   When defined, a starve counter watches the FIFO head. After the head has
//   waited STARVE_LIMIT consecutive cycles, alu_stall_out pulses for one
//   cycle and the head is popped in that cycle even if the ALU is valid.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset (0 = reset)
//   alu_valid_in/rd/data ALU result, no backpressure
//   lsu_valid_in/rd/data LSU result offer; lsu_ready_out = (count < DEPTH)
//   mark_valid_in/rd    set busy bit for an issued long-latency op
//   waddr_out/wdata_out/wen_out  registered register-file write port
//   busy_out            scoreboard, bit i = xi awaits an LSU write
//   fifo_count_out      FIFO occupancy
//   alu_stall_out       (WB_STARVE_GUARD_EN only) one-cycle forced-drain pulse
// -----------------------------------------------------------------------------
module int_wb_arbiter #(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    alu_valid_in,
   input  logic [4:0]              alu_rd_in,
   input  logic [31:0]             alu_data_in,
   input  logic                    lsu_valid_in,
   output logic                    lsu_ready_out,
   input  logic [4:0]              lsu_rd_in,
   input  logic [31:0]             lsu_data_in,
   input  logic                    mark_valid_in,
   input  logic [4:0]              mark_rd_in,
   output logic [4:0]              waddr_out,
   output logic [31:0]             wdata_out,
   output logic                    wen_out,
   output logic [31:0]             busy_out,
   output logic [$clog2(DEPTH):0]  fifo_count_out
`ifdef WB_STARVE_GUARD_EN
   ,
   output logic                    alu_stall_out
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   // Elaboration-time sanity check on the configuration.
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_param_check
      $error("int_wb_arbiter: DEPTH must be a power of two >= 2 and STARVE_LIMIT >= 1");
   end

   logic [4:0]    r_fifo_rd   [DEPTH];
   logic [31:0]   r_fifo_data [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic [4:0]    r_waddr;
   logic [31:0]   r_wdata;
   logic          r_wen;
   logic [31:0]   r_busy;

   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   logic          w_alu_sel;
   logic [4:0]    w_head_rd;
   logic [31:0]   w_head_data;
   logic [31:0]   w_set_mask;
   logic [31:0]   w_clr_mask;
   logic [31:0]   w_busy_next;

   assign w_empty       = (r_count == '0);
   assign lsu_ready_out = (r_count < CW'(DEPTH));
   assign w_push        = lsu_valid_in && lsu_ready_out;
   assign w_head_rd     = r_fifo_rd[r_rd_ptr];
   assign w_head_data   = r_fifo_data[r_rd_ptr];

`ifdef WB_STARVE_GUARD_EN
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic [SW-1:0] r_starve;
   logic          r_stall;
   logic [SW-1:0] w_starve_inc;

   // During the stall pulse the head is drained regardless of the ALU;
   // any ALU result offered in that cycle is lost (upstream violation).
   assign w_pop         = !w_empty && (r_stall || !alu_valid_in);
   assign w_starve_inc  = r_starve + SW'(1);
   assign alu_stall_out = r_stall;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_starve <= '0;
         r_stall  <= 1'b0;
      end else if (w_empty || w_pop) begin
         r_starve <= '0;
         r_stall  <= 1'b0;
      end else if (w_starve_inc == SW'(STARVE_LIMIT)) begin
         r_starve <= '0;
         r_stall  <= 1'b1;
      end else begin
         r_starve <= w_starve_inc;
         r_stall  <= 1'b0;
      end
   end
`else
   assign w_pop = !w_empty && !alu_valid_in;
`endif

   assign w_alu_sel = alu_valid_in && !w_pop;

   // FIFO storage: data only, no reset needed since occupancy is tracked.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_rd[r_wr_ptr]   <= lsu_rd_in;
         r_fifo_data[r_wr_ptr] <= lsu_data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   // Write port: x0 targets are consumed without raising wen; address and
   // data keep their previous values whenever no write is issued.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wen   <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
      end else if (w_alu_sel) begin
         r_wen <= (alu_rd_in != 5'd0);
         if (alu_rd_in != 5'd0) begin
            r_waddr <= alu_rd_in;
            r_wdata <= alu_data_in;
         end
      end else if (w_pop) begin
         r_wen <= (w_head_rd != 5'd0);
         if (w_head_rd != 5'd0) begin
            r_waddr <= w_head_rd;
            r_wdata <= w_head_data;
         end
      end else begin
         r_wen <= 1'b0;
      end
   end

   // Scoreboard: set has priority over a same-edge clear; bit 0 never sets.
   always_comb begin
      w_set_mask = '0;
      w_clr_mask = '0;
      if (mark_valid_in) w_set_mask[mark_rd_in] = 1'b1;
      if (w_pop)         w_clr_mask[w_head_rd]  = 1'b1;
      w_busy_next = ((r_busy & ~w_clr_mask) | w_set_mask) & ~32'h1;
   end

   always_ff @(posedge clk) begin
      if (!rst) r_busy <= '0;
      else      r_busy <= w_busy_next;
   end

   assign wen_out        = r_wen;
   assign waddr_out      = r_waddr;
   assign wdata_out      = r_wdata;
   assign busy_out       = r_busy;
   assign fifo_count_out = r_count;

endmodule
